// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: register map constants shared by the GPIO bank
package gpio_bank_pkg;
  localparam int REG_STRIDE = 4;
  localparam int NUM_REGS = 6;
  localparam int WINDOW_SIZE = REG_STRIDE * NUM_REGS;
  typedef enum logic [2:0] {OEN, DATA, IRQ_MASK, IRQ_EDGE, IRQ_POL, IRQ_STATUS} reg_e;
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: multi-stage input synchronizer with synchronous active-low reset
module gpio_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES*WIDTH-1:0] chain;
  always_ff @(posedge clk)
    chain <= !reset ? '0 : {chain[(STAGES-1)*WIDTH-1:0], d};
  assign q = chain[STAGES*WIDTH-1 -: WIDTH];
endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: port-mapped GPIO block with per-pin direction, data and maskable interrupts
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter logic [7:0] GPIO_BASE_ADDRESS = 8'h00,
  parameter int         GPIO_WIDTH = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            port_id,
  input  logic [7:0]            data_in,
  input  logic                  write_strobe,
  input  logic                  read_strobe,
  output logic [7:0]            data_out,
  output logic [GPIO_WIDTH-1:0] gpio_oen,
  output logic [GPIO_WIDTH-1:0] gpio_data_out,
  input  logic [GPIO_WIDTH-1:0] gpio_data_in,
  output logic                  interrupt
);
  localparam logic [2:0] ARMED = 3'(SYNC_STAGES + 1);
  logic [7:0] off;
  logic [1:0] b;
  logic [2:0] cnt;
  logic [31:0] rd32;
  logic in_win, wr, armed;
  reg_e k;
  logic [GPIO_WIDTH-1:0] wm, wd, mask, edge_mode, pol, status, sync, prev, ev, w1c, sel;

  gpio_sync #(.STAGES(SYNC_STAGES), .WIDTH(GPIO_WIDTH)) u_sync (
    .clk(clk), .reset(reset), .d(gpio_data_in), .q(sync)
  );

  // Byte-lane write mask/data; lanes beyond GPIO_WIDTH simply don't exist
  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_lane
    assign wm[i] = b == 2'(i / 8);
    assign wd[i] = data_in[i % 8];
  end

  always_comb begin
    off = port_id - GPIO_BASE_ADDRESS;
    in_win = off < 8'(WINDOW_SIZE);
    k = reg_e'(off[4:2]);
    b = off[1:0];
    wr = write_strobe && in_win;
    armed = cnt == ARMED;
    ev = armed ? (edge_mode & ((pol & sync & ~prev) | (~pol & ~sync & prev))) | (~edge_mode & ~(sync ^ pol)) : '0;
    w1c = wr && k == IRQ_STATUS ? wd & wm : '0;
    sel = k == OEN ? gpio_oen : k == DATA ? sync : k == IRQ_MASK ? mask :
          k == IRQ_EDGE ? edge_mode : k == IRQ_POL ? pol : k == IRQ_STATUS ? status : '0;
    rd32 = '0;
    rd32[GPIO_WIDTH-1:0] = sel;
  end

  always_ff @(posedge clk)
    if (!reset) begin
      gpio_oen <= '0;
      gpio_data_out <= '0;
      mask <= '0;
      edge_mode <= '0;
      pol <= '0;
      status <= '0;
      prev <= '0;
      cnt <= '0;
      data_out <= '0;
      interrupt <= '0;
    end else begin
      if (wr && k == OEN) gpio_oen <= (gpio_oen & ~wm) | (wd & wm);
      if (wr && k == DATA) gpio_data_out <= (gpio_data_out & ~wm) | (wd & wm);
      if (wr && k == IRQ_MASK) mask <= (mask & ~wm) | (wd & wm);
      if (wr && k == IRQ_EDGE) edge_mode <= (edge_mode & ~wm) | (wd & wm);
      if (wr && k == IRQ_POL) pol <= (pol & ~wm) | (wd & wm);
      status <= (status & ~w1c) | ev;
      prev <= sync;
      cnt <= armed ? cnt : cnt + 3'd1;
      interrupt <= |(status & mask);
      if (read_strobe) data_out <= in_win ? rd32[{b, 3'b000} +: 8] : 8'h00;
    end
endmodule
